// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank controller.
// Holds the register address map and the address type used by the
// register decode in gpio_bank_ctrl.
package gpio_bank_pkg;

    typedef logic [2:0] gpio_addr_t;

    localparam gpio_addr_t GPIO_DOUT     = 3'd0;
    localparam gpio_addr_t GPIO_DIR      = 3'd1;
    localparam gpio_addr_t GPIO_DIN      = 3'd2;
    localparam gpio_addr_t GPIO_IRQ_EN   = 3'd3;
    localparam gpio_addr_t GPIO_IRQ_POL  = 3'd4;
    localparam gpio_addr_t GPIO_IRQ_STAT = 3'd5;
    localparam gpio_addr_t GPIO_DB_LIM   = 3'd6;

endpackage

// File: rtl/gpio_bank_ctrl_db_chan.sv
// Per-channel synchronizer and debounce logic for gpio_bank_ctrl is
// implemented by module gpio_db_chan in gpio_db_chan.sv.

// File: rtl/gpio_db_chan.sv
// gpio_db_chan: one GPIO input channel.
// Two-flop synchronizer, saturating debounce counter and the update
// (edge) event used by the parent to set interrupt status.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   i_pad     : asynchronous pad input
//   i_db_lim  : debounce limit, shared by all channels
//   o_db      : debounced value
//   o_upd     : high in the cycle whose rising edge flips o_db
module gpio_db_chan #(
    parameter int DB_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_pad,
    input  logic [DB_W-1:0] i_db_lim,
    output logic            o_db,
    output logic            o_upd
);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic [DB_W-1:0] r_cnt;
    logic            w_mismatch;
    logic            w_upd;

    assign w_mismatch = r_sync2 ^ r_db;
    // ">=" so that a counter left above a freshly lowered limit accepts at once.
    assign w_upd      = w_mismatch && (r_cnt >= i_db_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_upd) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else if (r_cnt < i_db_lim) begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_db  = r_db;
    assign o_upd = w_upd;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: register-mapped GPIO bank with debounced inputs and
// edge interrupts.
//
// Ports
//   clk, rst_n        : clock / asynchronous active-low reset
//   gpio_in           : asynchronous pad inputs
//   gpio_out, gpio_oe : pad data / output enable (straight from DOUT / DIR)
//   wr_en, rd_en      : single-cycle register strobes
//   addr, wdata       : register index and write data
//   rdata, rd_valid   : read data, valid one cycle after rd_en
//   irq               : registered level interrupt
module gpio_bank_ctrl
    import gpio_bank_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DB_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] gpio_in,
    output logic [NUM_CH-1:0] gpio_out,
    output logic [NUM_CH-1:0] gpio_oe,
    input  logic              wr_en,
    input  logic              rd_en,
    input  gpio_addr_t        addr,
    input  logic [NUM_CH-1:0] wdata,
    output logic [NUM_CH-1:0] rdata,
    output logic              rd_valid,
    output logic              irq
);

    logic [NUM_CH-1:0] r_dout;
    logic [NUM_CH-1:0] r_dir;
    logic [NUM_CH-1:0] r_irq_en;
    logic [NUM_CH-1:0] r_irq_pol;
    logic [NUM_CH-1:0] r_irq_stat;
    logic [DB_W-1:0]   r_db_lim;
    logic [NUM_CH-1:0] r_rdata;
    logic              r_rd_valid;
    logic              r_irq;

    logic [NUM_CH-1:0] w_din;
    logic [NUM_CH-1:0] w_upd;
    logic [NUM_CH-1:0] w_set;
    logic [NUM_CH-1:0] w_w1c;
    logic [NUM_CH-1:0] w_rd_mux;
    logic [DB_W-1:0]   w_lim_wr;
    logic [NUM_CH-1:0] w_lim_rd;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        gpio_db_chan #(
            .DB_W(DB_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_pad    (gpio_in[g]),
            .i_db_lim (r_db_lim),
            .o_db     (w_din[g]),
            .o_upd    (w_upd[g])
        );
    end

    // The new debounced value is ~w_din, so it equals the polarity
    // exactly when the current value differs from it.
    assign w_set    = w_upd & (w_din ^ r_irq_pol);
    assign w_w1c    = (wr_en && addr == GPIO_IRQ_STAT) ? wdata : '0;
    assign w_lim_wr = DB_W'(wdata);
    assign w_lim_rd = NUM_CH'(r_db_lim);

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            GPIO_DOUT:     w_rd_mux = r_dout;
            GPIO_DIR:      w_rd_mux = r_dir;
            GPIO_DIN:      w_rd_mux = w_din;
            GPIO_IRQ_EN:   w_rd_mux = r_irq_en;
            GPIO_IRQ_POL:  w_rd_mux = r_irq_pol;
            GPIO_IRQ_STAT: w_rd_mux = r_irq_stat;
            GPIO_DB_LIM:   w_rd_mux = w_lim_rd;
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_pol  <= '1;
            r_irq_stat <= '0;
            r_db_lim   <= '1;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            // Read mux sees pre-write register values on a same-cycle write.
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rdata <= w_rd_mux;
            end
            r_irq      <= |(r_irq_stat & r_irq_en);
            // Set is OR-ed in after the clear so a coincident set wins.
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_set;
            if (wr_en) begin
                case (addr)
                    GPIO_DOUT:    r_dout    <= wdata;
                    GPIO_DIR:     r_dir     <= wdata;
                    GPIO_IRQ_EN:  r_irq_en  <= wdata;
                    GPIO_IRQ_POL: r_irq_pol <= wdata;
                    GPIO_DB_LIM:  r_db_lim  <= w_lim_wr;
                    default:      ;
                endcase
            end
        end
    end

    assign gpio_out = r_dout;
    assign gpio_oe  = r_dir;
    assign rdata    = r_rdata;
    assign rd_valid = r_rd_valid;
    assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
module tb_gpio_bank_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       irq;

    int checks = 0;
    int errors = 0;

    gpio_bank_ctrl #(.NUM_CH(8), .DB_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: register contents plus, per channel, the pad
    // history and the length of the current run of disagreeing samples.
    bit [7:0] m_dout, m_dir, m_en, m_pol, m_stat, m_db;
    bit [7:0] m_p1, m_p2;
    int       m_lim;
    int       m_run [8];
    bit       m_irq, m_rvalid;
    bit [7:0] m_rdata;

    bit [7:0] rst_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h0F, 8'h00};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_dout = 0; m_dir = 0; m_en = 0; m_pol = 8'hFF; m_stat = 0; m_db = 0;
        m_p1 = 0; m_p2 = 0; m_lim = 15; m_irq = 0; m_rvalid = 0; m_rdata = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endfunction

    function automatic void model_step(bit [7:0] pad, bit wr, bit rd, bit [2:0] a, bit [7:0] wd);
        bit [7:0] rv;
        bit [7:0] set_v;
        bit [7:0] clr_v;
        set_v = 0;
        clr_v = 0;
        case (a)
            3'd0: rv = m_dout;
            3'd1: rv = m_dir;
            3'd2: rv = m_db;
            3'd3: rv = m_en;
            3'd4: rv = m_pol;
            3'd5: rv = m_stat;
            3'd6: rv = 8'(m_lim);
            default: rv = 0;
        endcase
        m_rvalid = rd;
        if (rd) m_rdata = rv;
        m_irq = |(m_stat & m_en);
        // A new level is accepted once it has disagreed for lim+1 samples in a row.
        for (int c = 0; c < 8; c++) begin
            if (m_p2[c] != m_db[c]) begin
                m_run[c]++;
                if (m_run[c] > m_lim) begin
                    m_db[c]  = m_p2[c];
                    m_run[c] = 0;
                    if (m_db[c] == m_pol[c]) set_v[c] = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_p2 = m_p1;
        m_p1 = pad;
        if (wr && a == 3'd5) clr_v = wd;
        m_stat = (m_stat & ~clr_v) | set_v;
        if (wr) begin
            case (a)
                3'd0: m_dout = wd;
                3'd1: m_dir  = wd;
                3'd3: m_en   = wd;
                3'd4: m_pol  = wd;
                3'd6: m_lim  = int'(wd & 8'h0F);
                default: ;
            endcase
        end
    endfunction

    // One clock: capture inputs, advance the model, compare all outputs.
    task automatic cycle();
        bit [7:0] pad;
        bit wr, rd;
        bit [2:0] a;
        bit [7:0] wd;
        pad = gpio_in; wr = wr_en; rd = rd_en; a = addr; wd = wdata;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_step(pad, wr, rd, a, wd);
        chk("gpio_out", gpio_out, m_dout);
        chk("gpio_oe", gpio_oe, m_dir);
        chk("irq", irq, m_irq);
        chk("rd_valid", rd_valid, m_rvalid);
        if (m_rvalid) chk("rdata", rdata, m_rdata);
    endtask

    task automatic wr(input bit [2:0] a, input bit [7:0] d);
        wr_en = 1; addr = a; wdata = d;
        cycle();
        wr_en = 0;
    endtask

    task automatic rd(input bit [2:0] a, output bit [7:0] v);
        rd_en = 1; addr = a;
        cycle();
        rd_en = 0;
        v = rdata;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit [7:0] v;
        rst_n = 0; gpio_in = 0; wr_en = 0; rd_en = 0; addr = 0; wdata = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;

        // Reset values
        chk("rst_oe", gpio_oe, 8'h00);
        chk("rst_irq", irq, 1'b0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk($sformatf("rst_rd%0d", a), v, rst_exp[a]);
        end

        // Held rise on ch3 with DB_LIM=2: DIN after edge 5, irq after edge 6
        wr(3'd6, 8'd2);
        wr(3'd3, 8'h08);
        gpio_in[3] = 1;
        rd_en = 1; addr = 3'd2;
        for (int e = 1; e <= 6; e++) begin
            cycle();
            if (e == 5) begin
                chk("din3_edge4", rdata[3], 1'b0);
                chk("irq_edge5", irq, 1'b0);
            end
            if (e == 6) begin
                chk("din3_edge5", rdata[3], 1'b1);
                chk("irq_edge6", irq, 1'b1);
            end
        end
        rd_en = 0;
        wr(3'd5, 8'hFF);
        wr(3'd3, 8'h00);

        // Two-cycle glitch on ch0 is discarded
        gpio_in[0] = 1;
        cycle(); cycle();
        gpio_in[0] = 0;
        repeat (10) cycle();
        rd(3'd2, v);
        chk("glitch_din0", v[0], 1'b0);
        rd(3'd5, v);
        chk("glitch_stat", v, 8'h00);

        // Falling-edge polarity on ch5, then W1C
        wr(3'd4, 8'hDF);
        gpio_in[5] = 1;
        repeat (10) cycle();
        rd(3'd5, v);
        chk("pol_rise_stat5", v[5], 1'b0);
        gpio_in[5] = 0;
        repeat (10) cycle();
        rd(3'd5, v);
        chk("pol_fall_stat5", v[5], 1'b1);
        wr(3'd3, 8'h20);
        cycle();
        chk("pol_irq_on", irq, 1'b1);
        wr(3'd5, 8'h20);
        cycle();
        chk("w1c_irq_off", irq, 1'b0);
        rd(3'd5, v);
        chk("w1c_stat5", v[5], 1'b0);

        // W1C on the very edge bit 2 sets: set wins
        gpio_in[2] = 1;
        repeat (4) cycle();
        wr(3'd5, 8'h04);
        rd(3'd5, v);
        chk("set_beats_w1c", v[2], 1'b1);
        wr(3'd5, 8'hFF);

        // Randomized traffic, DB_LIM only changed while every channel is settled
        for (int seg = 0; seg < 3; seg++) begin
            repeat (30) cycle();
            wr(3'd6, 8'($urandom_range(0, 3)));
            for (int n = 0; n < 300; n++) begin
                int r;
                for (int c = 0; c < 8; c++)
                    if ($urandom_range(0, 5) == 0) gpio_in[c] = ~gpio_in[c];
                r = $urandom_range(0, 9);
                rd_en = (r < 4) || (r == 9);
                wr_en = (r >= 4 && r < 7) || (r == 9);
                addr  = 3'($urandom_range(0, 7));
                if (wr_en && addr == 3'd6) addr = 3'd5;
                wdata = 8'($urandom);
                cycle();
                wr_en = 0; rd_en = 0;
            end
        end

        // Reset asserted in the middle of a pending read
        wr(3'd1, 8'hA5);
        wr(3'd0, 8'h3C);
        chk("pre_rst_oe", gpio_oe, 8'hA5);
        chk("pre_rst_out", gpio_out, 8'h3C);
        rd_en = 1; addr = 3'd0;
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_oe", gpio_oe, 8'h00);
        chk("mid_rst_out", gpio_out, 8'h00);
        chk("mid_rst_rdv", rd_valid, 1'b0);
        model_reset();
        rd_en = 0;
        cycle();
        cycle();
        rst_n = 1;
        repeat (3) begin
            cycle();
            chk("post_rst_rdv", rd_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_bank_ctrl.md
GPIO_BANK_CTRL -- requirements
Module: gpio_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of GPIO channels, legal range 1..32.
REQ-002 SHALL have parameter DB_W, default 4: debounce counter width, legal range 1..16.
REQ-003 SHALL have port clk, input, 1: sole clock; all flops rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port gpio_in, input, NUM_CH: asynchronous pad inputs.
REQ-006 SHALL have port gpio_out, output, NUM_CH: pad output data.
REQ-007 SHALL have port gpio_oe, output, NUM_CH: pad output enable, 1 = drive.
REQ-008 SHALL have port wr_en, input, 1: register write strobe, single cycle.
REQ-009 SHALL have port rd_en, input, 1: register read strobe, single cycle.
REQ-010 SHALL have port addr, input, 3: register index.
REQ-011 SHALL have port wdata, input, NUM_CH: write data.
REQ-012 SHALL have port rdata, output, NUM_CH: read data, LSB-aligned, zero-extended.
REQ-013 SHALL have port rd_valid, output, 1: rdata qualifier.
REQ-014 SHALL have port irq, output, 1: level interrupt.

Function
REQ-015 SHALL decode this register map: 0 DOUT (rw), 1 DIR (rw), 2 DIN (ro, debounced inputs), 3 IRQ_EN (rw), 4 IRQ_POL (rw; 1 = rising edge, 0 = falling edge), 5 IRQ_STAT (read; write-1-to-clear), 6 DB_LIM (rw, low DB_W bits).
REQ-016 SHALL drive gpio_out directly from DOUT and gpio_oe directly from DIR.
REQ-017 SHALL pass each gpio_in bit through a 2-flop synchronizer before any other use.
REQ-018 SHALL keep one DB_W-bit counter per channel: clear it when the synchronized value equals the debounced value, otherwise increment it, saturating at DB_LIM.
REQ-019 SHALL update the debounced bit, and clear its counter, on the edge where the value mismatches and counter == DB_LIM; DB_LIM = 0 therefore accepts a change after 1 mismatch cycle.
REQ-020 SHALL make a pad change held stable reach DIN exactly 3+DB_LIM clk edges after the first sampling edge.
REQ-021 SHALL discard a glitch shorter than DB_LIM+1 synchronized cycles, leaving DIN unchanged.
REQ-022 SHALL set IRQ_STAT[i] on the same edge DIN[i] updates, when the new value matches IRQ_POL[i]; this is independent of IRQ_EN.
REQ-023 SHALL register irq as |(IRQ_STAT & IRQ_EN), so irq is valid 1 cycle after the status change.
REQ-024 SHALL give set priority over clear when a W1C and a status set hit the same bit on the same edge.
REQ-025 SHALL return read data 1 cycle after rd_en, with rd_valid high for exactly that cycle.
REQ-026 SHALL read unmapped address 7 as 0 and ignore writes to it; writes to DIN are ignored.
REQ-027 SHALL, when wr_en and rd_en coincide on the same address, return the pre-write value.
REQ-028 SHALL leave in-flight counters unchanged when DB_LIM is written; comparisons use the new limit from the next edge, and counters above the new limit accept on that edge.

Reset
REQ-029 SHALL asynchronously clear, on rst_n low: DOUT, DIR, IRQ_EN, IRQ_STAT, synchronizers, debounced bits, counters, rdata, rd_valid and irq to 0, IRQ_POL to all-ones, and DB_LIM to all-ones.
REQ-030 SHALL abort debounce and pending reads when reset is asserted mid-operation, with no rd_valid pulse after reset releases.

Structure
REQ-031 SHALL place the register address constants (GPIO_DOUT..GPIO_DB_LIM) and the address typedef in a shared package, gpio_bank_pkg.
REQ-032 SHALL implement the per-channel synchronizer, debounce counter and edge detect as sub-module gpio_db_chan, instantiated NUM_CH times in a generate loop.

Verification
REQ-033 Reset, then read all registers -> DOUT=0, DIR=0, IRQ_POL=0xFF, DB_LIM=0xF, IRQ_STAT=0, irq=0, gpio_oe=0.
REQ-034 DB_LIM=2, ch3 rises and is held -> DIN[3]=1 exactly 5 edges later; IRQ_STAT[3]=1 on that edge; with IRQ_EN[3]=1, irq=1 one edge later.
REQ-035 DB_LIM=2, ch0 pulse 2 cycles wide -> DIN[0] stays 0, IRQ_STAT stays 0.
REQ-036 IRQ_POL[5]=0, ch5 goes 1 then 0, each level held 10 cycles -> only the falling transition sets IRQ_STAT[5]; W1C 0x20 then clears it and drops irq.
REQ-037 W1C to bit 2 on the same edge that bit 2 sets -> IRQ_STAT[2] remains 1.
REQ-038 Write DIR=0xA5, DOUT=0x3C, then assert rst_n low mid-read -> gpio_oe=0 and gpio_out=0 immediately, with no rd_valid pulse.
